// File: rtl/lru_pkg.sv
// lru_pkg: op encodings, controller states and rank-width helper for the LRU set controller.
package lru_pkg;
  localparam logic [1:0] LRU_OP_TOUCH = 2'b00;
  localparam logic [1:0] LRU_OP_FILL  = 2'b01;
  localparam logic [1:0] LRU_OP_INVAL = 2'b10;
  localparam logic [1:0] LRU_OP_PEEK  = 2'b11;
  typedef enum logic {ST_INIT, ST_RUN} lru_state_e;
  function automatic int rank_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/lru_rank_update.sv
// lru_rank_update: next-rank, victim and error computation for one set's rank permutation.
module lru_rank_update
  import lru_pkg::*;
#(
  parameter  int WAYS  = 8,
  localparam int WAY_W = rank_w(WAYS)
) (
  input  logic [WAYS*WAY_W-1:0] ranks_i,
  input  logic [1:0]            op_i,
  input  logic [WAYS-1:0]       way_i,
  output logic [WAYS*WAY_W-1:0] ranks_o,
  output logic [WAY_W-1:0]      victim_o,
  output logic                  err_o
);
  localparam logic [WAY_W-1:0] MRU = WAY_W'(WAYS - 1);
  logic [WAY_W-1:0] sel_rank, lru_pre, lru_post, r, n;
  logic             one_hot;
  always_comb begin
    one_hot  = (way_i != '0) && ((way_i & (way_i - 1'b1)) == '0);
    err_o    = ((op_i == LRU_OP_TOUCH) || (op_i == LRU_OP_INVAL)) && !one_hot;
    sel_rank = '0;
    lru_pre  = '0;
    lru_post = '0;
    r        = '0;
    n        = '0;
    ranks_o  = ranks_i;
    for (int i = 0; i < WAYS; i++) begin
      r        = ranks_i[i*WAY_W +: WAY_W];
      sel_rank = sel_rank | (way_i[i] ? r : '0);
      lru_pre  = (r == '0) ? WAY_W'(i) : lru_pre;
    end
    // a rejected request leaves the permutation untouched, so lru_post equals lru_pre
    for (int i = 0; i < WAYS; i++) begin
      r = ranks_i[i*WAY_W +: WAY_W];
      n = err_o ? r :
          (op_i == LRU_OP_TOUCH) ? (way_i[i] ? MRU : (r > sel_rank) ? r - 1'b1 : r) :
          (op_i == LRU_OP_FILL)  ? ((r == '0) ? MRU : r - 1'b1) :
          (op_i == LRU_OP_INVAL) ? (way_i[i] ? '0 : (r < sel_rank) ? r + 1'b1 : r) : r;
      ranks_o[i*WAY_W +: WAY_W] = n;
      lru_post = (n == '0) ? WAY_W'(i) : lru_post;
    end
    victim_o = (op_i == LRU_OP_FILL) ? lru_pre : lru_post;
  end
endmodule

// File: rtl/lru_set_ctrl.sv
// lru_set_ctrl: multi-set true-LRU rank array with registered victim response.
module lru_set_ctrl
  import lru_pkg::*;
#(
  parameter  int WAYS  = 8,
  parameter  int SETS  = 64,
  localparam int WAY_W = rank_w(WAYS),
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [1:0]             i_req_op,
  input  logic [SET_W-1:0]       i_req_set,
  input  logic [WAYS-1:0]        i_req_way,
  output logic                   o_resp_valid,
  output logic [WAY_W-1:0]       o_resp_victim_idx,
  output logic [WAYS-1:0]        o_resp_victim_oh,
  output logic                   o_resp_err,
  input  logic [SET_W-1:0]       i_dbg_set,
  output logic [WAYS*WAY_W-1:0]  o_dbg_ranks
);
  localparam int RW = WAYS * WAY_W;
  lru_state_e       state_q, state_d;
  logic [RW-1:0]    ranks_q [SETS];
  logic [RW-1:0]    ident, next_ranks;
  logic [WAY_W-1:0] victim_d, victim_q;
  logic             err_d, err_q, resp_valid_q, accept;
  always_comb begin
    ident = '0;
    for (int i = 0; i < WAYS; i++) ident[i*WAY_W +: WAY_W] = WAY_W'(i);
  end
  always_comb begin
    state_d     = (state_q == ST_INIT) ? ST_RUN : state_q;
    o_req_ready = (state_q == ST_RUN);
    accept      = i_req_valid && o_req_ready;
  end
  lru_rank_update #(.WAYS(WAYS)) u_upd (
    .ranks_i  (ranks_q[i_req_set]),
    .op_i     (i_req_op),
    .way_i    (i_req_way),
    .ranks_o  (next_ranks),
    .victim_o (victim_d),
    .err_o    (err_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      resp_valid_q <= 1'b0;
      victim_q     <= '0;
      err_q        <= 1'b0;
      for (int s = 0; s < SETS; s++) ranks_q[s] <= ident;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= accept;
      if (accept) begin
        ranks_q[i_req_set] <= next_ranks;
        victim_q           <= victim_d;
        err_q              <= err_d;
      end
    end
  end
  assign o_resp_valid      = resp_valid_q;
  assign o_resp_victim_idx = victim_q;
  assign o_resp_victim_oh  = WAYS'(1) << victim_q;
  assign o_resp_err        = err_q;
  assign o_dbg_ranks       = ranks_q[i_dbg_set];
endmodule
